// File: rtl/tx_am_pkg.sv
// tx_am_pkg: shared constants for the TX alignment-marker inserter.
// FSM state encodings, per-lane AM patterns (also used by the RX AM-lock
// compare) and the fill word sent when upstream has nothing to send.
package tx_am_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_AM   = 2'b01,
        ST_DATA = 2'b10
    } txam_state_e;

    localparam logic [15:0] IDLE_WORD = 16'h0707;

    // Per-lane AM pattern; lanes beyond 3 reuse the pattern set cyclically.
    function automatic logic [15:0] am_pat(input int k);
        logic [15:0] p;
        case (k % 4)
            0:       p = 16'hC168;
            1:       p = 16'h9D71;
            2:       p = 16'hB5E2;
            default: p = 16'h4A3F;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tx_am_bip.sv
// tx_am_bip: per-lane 8-bit bit-interleaved parity accumulator.
// Folds both bytes of every word sent on the lane; clear has priority.
// Only instantiated when TX_AM_BIP_EN is defined.
module tx_am_bip (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_acc,
    input  logic [15:0] i_word,
    output logic [7:0]  o_bip
);

    // Accumulate XOR of both bytes; cleared at each AM slot or resync.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bip <= 8'h00;
        end else if (i_clr) begin
            o_bip <= 8'h00;
        end else if (i_acc) begin
            o_bip <= o_bip ^ i_word[15:8] ^ i_word[7:0];
        end
    end

endmodule

// File: rtl/tx_am_insert.sv
// tx_am_insert: TX alignment-marker inserter.
// Stripes upstream words onto LNUM lanes and inserts an AM word on all
// enabled lanes every period_q data slots. Optional macro TX_AM_BIP_EN
// folds a per-lane BIP into the low byte of the AM word.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   IDLE    | no output; waits for nonzero period and any lane enabled
//   AM      | emits AM on enabled lanes, latches the period
//   DATA    | emits upstream data or fill, counts slots to next AM
module tx_am_insert
    import tx_am_pkg::*;
#(
    parameter int LNUM = 4,
    parameter int DW   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [LNUM-1:0]   i_lden,
    input  logic [15:0]       i_am_period,
    input  logic              i_tx_en,
    input  logic [LNUM*DW-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [LNUM*DW-1:0] o_data,
    output logic              o_valid,
    output logic [LNUM-1:0]   o_is_am,
    output logic [1:0]        o_txam_fsm
);

    txam_state_e        state_q, state_d;
    logic [15:0]        slot_cnt_q, slot_cnt_d;
    logic [15:0]        period_q, period_d;
    logic [LNUM-1:0]    lden_q;
    logic               resync;
    logic               xfer;
    logic [LNUM*DW-1:0] am_bus;
    logic [LNUM*DW-1:0] data_bus;

    // A lane-set change or a zero period restarts the marker sequence.
    assign resync     = (i_lden != lden_q) || (i_am_period == 16'd0);
    assign o_ready    = i_tx_en & (state_q == ST_DATA) & (|i_lden);
    assign xfer       = i_valid & o_ready;
    assign o_txam_fsm = state_q;

`ifdef TX_AM_BIP_EN
    logic [7:0]  bip [LNUM];
    logic [15:0] pat;
    logic        bip_clr;
    logic        bip_acc;

    assign bip_clr = resync | (i_tx_en & (state_q == ST_AM));
    assign bip_acc = i_tx_en & (state_q == ST_DATA);

    for (genvar g = 0; g < LNUM; g++) begin : g_bip
        tx_am_bip u_bip (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (bip_clr),
            .i_acc   (bip_acc),
            .i_word  (data_bus[g*DW +: 16]),
            .o_bip   (bip[g])
        );
    end

    // Build AM and data lane words; disabled lanes stay zero.
    always_comb begin
        am_bus   = '0;
        data_bus = '0;
        pat      = '0;
        for (int k = 0; k < LNUM; k++) begin
            pat = am_pat(k);
            if (i_lden[k]) begin
                am_bus[k*DW +: DW]   = DW'({pat[15:8], bip[k]});
                data_bus[k*DW +: DW] = xfer ? i_data[k*DW +: DW] : DW'(IDLE_WORD);
            end
        end
    end
`else
    // Build AM and data lane words; disabled lanes stay zero.
    always_comb begin
        am_bus   = '0;
        data_bus = '0;
        for (int k = 0; k < LNUM; k++) begin
            if (i_lden[k]) begin
                am_bus[k*DW +: DW]   = DW'(am_pat(k));
                data_bus[k*DW +: DW] = xfer ? i_data[k*DW +: DW] : DW'(IDLE_WORD);
            end
        end
    end
`endif

    // Next-state, slot counter and period latch; resync overrides everything.
    always_comb begin
        state_d    = state_q;
        slot_cnt_d = slot_cnt_q;
        period_d   = period_q;
        if (i_tx_en) begin
            case (state_q)
                ST_IDLE: begin
                    if ((i_am_period != 16'd0) && (|i_lden)) begin
                        state_d = ST_AM;
                    end
                end
                ST_AM: begin
                    state_d    = ST_DATA;
                    period_d   = i_am_period;
                    slot_cnt_d = 16'd0;
                end
                ST_DATA: begin
                    if (slot_cnt_q == (period_q - 16'd1)) begin
                        state_d    = ST_AM;
                        slot_cnt_d = 16'd0;
                    end else begin
                        slot_cnt_d = slot_cnt_q + 16'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (resync) begin
            state_d    = ST_IDLE;
            slot_cnt_d = 16'd0;
        end
    end

    // State, counter, period and lane-enable history registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            slot_cnt_q <= 16'd0;
            period_q   <= 16'd0;
            lden_q     <= '0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            period_q   <= period_d;
            lden_q     <= i_lden;
        end
    end

    // Registered lane outputs; words hold between strobes, valid pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_is_am <= '0;
        end else begin
            o_valid <= 1'b0;
            if (i_tx_en) begin
                case (state_q)
                    ST_AM: begin
                        o_valid <= 1'b1;
                        o_data  <= am_bus;
                        o_is_am <= i_lden;
                    end
                    ST_DATA: begin
                        o_valid <= 1'b1;
                        o_data  <= data_bus;
                        o_is_am <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_am_insert.sv
// tb_tx_am_insert: directed bench for tx_am_insert (LNUM=4, DW=16).
// Covers reset, AM schedule, throttling, starvation fill, lane change,
// period change/disable, AM BIP/pattern content and asynchronous reset.
module tb_tx_am_insert;

    localparam logic [15:0] P0 = 16'hC168;
    localparam logic [15:0] P1 = 16'h9D71;
    localparam logic [15:0] P2 = 16'hB5E2;
    localparam logic [15:0] P3 = 16'h4A3F;
    localparam logic [15:0] IW = 16'h0707;
    localparam logic [1:0]  S_IDLE = 2'b00;
    localparam logic [1:0]  S_AM   = 2'b01;
    localparam logic [1:0]  S_DATA = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  lden;
    logic [15:0] period;
    logic        tx_en;
    logic        vld;
    logic [63:0] din;
    logic        rdy;
    logic [63:0] dout;
    logic        ov;
    logic [3:0]  is_am;
    logic [1:0]  fsm;
    logic        rdy_pre;
    logic [63:0] exp_t6;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    tx_am_insert #(.LNUM(4), .DW(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_lden      (lden),
        .i_am_period (period),
        .i_tx_en     (tx_en),
        .i_data      (din),
        .i_valid     (vld),
        .o_ready     (rdy),
        .o_data      (dout),
        .o_valid     (ov),
        .o_is_am     (is_am),
        .o_txam_fsm  (fsm)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] n);
        return {16'h3000 + n, 16'h2000 + n, 16'h1000 + n, n};
    endfunction

    // AM bus for a lane mask, with BIP (if built) assumed cleared.
    function automatic logic [63:0] am_exp(input logic [3:0] m);
        logic [15:0] p [4];
        logic [63:0] r;
        p = '{P0, P1, P2, P3};
        r = '0;
        for (int k = 0; k < 4; k++) begin
`ifdef TX_AM_BIP_EN
            p[k][7:0] = 8'h00;
`endif
            if (m[k]) r[k*16 +: 16] = p[k];
        end
        return r;
    endfunction

    task automatic step(input logic en, input logic v, input logic [63:0] d);
        tx_en = en;
        vld   = v;
        din   = d;
        #1;
        rdy_pre = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [63:0] d,
                              input logic [3:0] a, input logic [1:0] f);
        chk({tag, ".valid"}, 64'(ov), 64'(v));
        chk({tag, ".data"},  dout, d);
        chk({tag, ".is_am"}, 64'(is_am), 64'(a));
        chk({tag, ".fsm"},   64'(fsm), 64'(f));
    endtask

    initial begin
        lden = 4'hF; period = 16'd4; tx_en = 1'b1; vld = 1'b0; din = '0; rdy_pre = 1'b0;

        // Reset values
        #12;
        expect_out("reset", 1'b0, 64'h0, 4'h0, S_IDLE);
        chk("reset.ready", 64'(rdy), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: lden history resync, IDLE->AM, AM out, 4 data slots, AM again
        step(1'b1, 1'b1, mk(1));
        chk("t1_s1.ready", 64'(rdy_pre), 64'h0);
        chk("t1_s1.valid", 64'(ov), 64'h0);
        chk("t1_s1.fsm", 64'(fsm), 64'(S_IDLE));
        step(1'b1, 1'b1, mk(1));
        chk("t1_s2.valid", 64'(ov), 64'h0);
        chk("t1_s2.fsm", 64'(fsm), 64'(S_AM));
        step(1'b1, 1'b1, mk(1));
        chk("t1_am.ready", 64'(rdy_pre), 64'h0);
        expect_out("t1_am", 1'b1, am_exp(4'hF), 4'hF, S_DATA);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, mk(16'(i)));
            chk("t1_data.ready", 64'(rdy_pre), 64'h1);
            expect_out("t1_data", 1'b1, mk(16'(i)), 4'h0, (i == 4) ? S_AM : S_DATA);
        end
        step(1'b1, 1'b1, mk(5));
        chk("t1_am2.ready", 64'(rdy_pre), 64'h0);
        chk("t1_am2.valid", 64'(ov), 64'h1);
        chk("t1_am2.is_am", 64'(is_am), 64'hF);

        // T2: throttled strobes, outputs hold between strobes
        for (int i = 5; i <= 8; i++) begin
            step(1'b1, 1'b1, mk(16'(i)));
            expect_out("t2_data", 1'b1, mk(16'(i)), 4'h0, (i == 8) ? S_AM : S_DATA);
            step(1'b0, 1'b1, mk(16'(i + 1)));
            chk("t2_gap.ready", 64'(rdy_pre), 64'h0);
            expect_out("t2_gap", 1'b0, mk(16'(i)), 4'h0, (i == 8) ? S_AM : S_DATA);
        end
        step(1'b1, 1'b1, mk(9));
        chk("t2_am.valid", 64'(ov), 64'h1);
        chk("t2_am.is_am", 64'(is_am), 64'hF);

        // T3: starvation fill counts toward the period
        for (int j = 0; j < 6; j++) begin
            step(1'b1, 1'b0, mk(9));
            if (j == 4) begin
                chk("t3_am.ready", 64'(rdy_pre), 64'h0);
                chk("t3_am.is_am", 64'(is_am), 64'hF);
                chk("t3_am.fsm", 64'(fsm), 64'(S_DATA));
            end else begin
                chk("t3_fill.ready", 64'(rdy_pre), 64'h1);
                expect_out("t3_fill", 1'b1, {IW, IW, IW, IW}, 4'h0, (j == 3) ? S_AM : S_DATA);
            end
        end

        // T4: lane mask change mid-period
        lden = 4'h5;
        step(1'b1, 1'b1, mk(9));
        expect_out("t4_chg", 1'b1, {16'h0000, 16'h2009, 16'h0000, 16'h0009}, 4'h0, S_IDLE);
        step(1'b1, 1'b1, mk(10));
        chk("t4_idle.ready", 64'(rdy_pre), 64'h0);
        chk("t4_idle.valid", 64'(ov), 64'h0);
        chk("t4_idle.fsm", 64'(fsm), 64'(S_AM));
        step(1'b1, 1'b1, mk(10));
        expect_out("t4_am", 1'b1, am_exp(4'h5), 4'h5, S_DATA);
        lden = 4'hF;
        step(1'b1, 1'b1, mk(10));
        expect_out("t4_back", 1'b1, mk(10), 4'h0, S_IDLE);
        step(1'b1, 1'b1, mk(11));
        step(1'b1, 1'b1, mk(11));
        expect_out("t4_am2", 1'b1, am_exp(4'hF), 4'hF, S_DATA);

        // T5: period change takes effect at the next AM; then disable
        for (int i = 11; i <= 14; i++) begin
            if (i == 12) period = 16'd8;
            step(1'b1, 1'b1, mk(16'(i)));
            expect_out("t5_p4", 1'b1, mk(16'(i)), 4'h0, (i == 14) ? S_AM : S_DATA);
        end
        step(1'b1, 1'b1, mk(15));
        chk("t5_am.is_am", 64'(is_am), 64'hF);
        for (int i = 15; i <= 22; i++) begin
            step(1'b1, 1'b1, mk(16'(i)));
            expect_out("t5_p8", 1'b1, mk(16'(i)), 4'h0, (i == 22) ? S_AM : S_DATA);
        end
        step(1'b1, 1'b1, mk(23));
        chk("t5_am2.is_am", 64'(is_am), 64'hF);
        period = 16'd0;
        step(1'b1, 1'b1, mk(23));
        chk("t5_dis.fsm", 64'(fsm), 64'(S_IDLE));
        step(1'b1, 1'b1, mk(24));
        chk("t5_dis.ready", 64'(rdy_pre), 64'h0);
        chk("t5_dis.valid", 64'(ov), 64'h0);
        step(1'b1, 1'b1, mk(24));
        chk("t5_dis2.fsm", 64'(fsm), 64'(S_IDLE));

        // T6: AM content after lane0 sends 1234, 00FF
        period = 16'd2;
        step(1'b1, 1'b1, 64'h0);
        chk("t6_idle.fsm", 64'(fsm), 64'(S_AM));
        step(1'b1, 1'b1, 64'h0);
        expect_out("t6_am0", 1'b1, am_exp(4'hF), 4'hF, S_DATA);
        step(1'b1, 1'b1, {48'h0, 16'h1234});
        expect_out("t6_d0", 1'b1, {48'h0, 16'h1234}, 4'h0, S_DATA);
        step(1'b1, 1'b1, {48'h0, 16'h00FF});
        expect_out("t6_d1", 1'b1, {48'h0, 16'h00FF}, 4'h0, S_AM);
        exp_t6 = am_exp(4'hF);
`ifdef TX_AM_BIP_EN
        exp_t6[7:0] = 8'hD9;
`endif
        step(1'b1, 1'b0, 64'h0);
        expect_out("t6_am", 1'b1, exp_t6, 4'hF, S_DATA);

        // Asynchronous reset mid-operation
        step(1'b1, 1'b1, mk(1));
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("arst", 1'b0, 64'h0, 4'h0, S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
